// File: rtl/float_triplet_collector_if.sv
// rtl/float_triplet_collector_if.sv - word-in / triple-out stream bundle for the triplet collector
interface float_triplet_collector_if #(
    parameter int FLEN = 64
);
    logic                      up_valid;
    logic                      up_ready;
    logic [FLEN-1:0]           up_data;
    logic                      down_valid;
    logic                      down_ready;
    logic [0:2][FLEN-1:0]      down_data;
`ifdef FLOAT_TRIPLET_SPECIAL_EN
    logic                      down_special;
`endif

    // master: upstream producer and downstream sorter; slave: the collector
    modport master (
        output up_valid, up_data, down_ready,
        input  up_ready, down_valid, down_data
`ifdef FLOAT_TRIPLET_SPECIAL_EN
        , input down_special
`endif
    );

    modport slave (
        input  up_valid, up_data, down_ready,
        output up_ready, down_valid, down_data
`ifdef FLOAT_TRIPLET_SPECIAL_EN
        , output down_special
`endif
    );
endinterface

// File: rtl/float_triplet_collector.sv
// rtl/float_triplet_collector.sv - groups a float word stream into double-buffered triples
// Optional NaN/Inf flag output enabled by FLOAT_TRIPLET_SPECIAL_EN.
module float_triplet_collector #(
    parameter int FLEN  = 64,
    parameter int EXP_W = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    float_triplet_collector_if.slave bus
);
    if (EXP_W < 1 || EXP_W > FLEN - 1) begin : g_bad_exp_w
        $error("EXP_W must fit below the sign bit");
    end

    typedef enum logic [1:0] {
        E0,
        E1,
        E2,
        FULL
    } state_t;

    state_t            state;
    logic [FLEN-1:0]   col [0:2];
    logic              accept;
    logic              out_free;

    assign bus.up_ready = !rst && (state != FULL);
    assign accept       = bus.up_valid && bus.up_ready;
    assign out_free     = !bus.down_valid || bus.down_ready;

`ifdef FLOAT_TRIPLET_SPECIAL_EN
    function automatic logic is_special(input logic [FLEN-1:0] w);
        return &w[FLEN-2 -: EXP_W];
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= E0;
            bus.down_valid <= 1'b0;
            bus.down_data  <= '0;
            col[0]         <= '0;
            col[1]         <= '0;
            col[2]         <= '0;
`ifdef FLOAT_TRIPLET_SPECIAL_EN
            bus.down_special <= 1'b0;
`endif
        end else begin
            // A load below overrides this clear, giving gapless drain+load.
            if (bus.down_valid && bus.down_ready) begin
                bus.down_valid <= 1'b0;
            end
            case (state)
                E0: begin
                    if (accept) begin
                        col[0] <= bus.up_data;
                        state  <= E1;
                    end
                end
                E1: begin
                    if (accept) begin
                        col[1] <= bus.up_data;
                        state  <= E2;
                    end
                end
                E2: begin
                    if (accept) begin
                        if (out_free) begin
                            bus.down_data  <= {col[0], col[1], bus.up_data};
                            bus.down_valid <= 1'b1;
`ifdef FLOAT_TRIPLET_SPECIAL_EN
                            bus.down_special <= is_special(col[0]) || is_special(col[1])
                                                || is_special(bus.up_data);
`endif
                            state <= E0;
                        end else begin
                            col[2] <= bus.up_data;
                            state  <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (out_free) begin
                        bus.down_data  <= {col[0], col[1], col[2]};
                        bus.down_valid <= 1'b1;
`ifdef FLOAT_TRIPLET_SPECIAL_EN
                        bus.down_special <= is_special(col[0]) || is_special(col[1])
                                            || is_special(col[2]);
`endif
                        state <= E0;
                    end
                end
                default: state <= E0;
            endcase
        end
    end
endmodule

// File: tb/tb_float_triplet_collector.sv
// tb/tb_float_triplet_collector.sv - directed and random bench with a queue-based buffer model
module tb_float_triplet_collector;
    localparam int FLEN  = 64;
    localparam int EXP_W = 11;

    localparam logic [FLEN-1:0] F1   = 64'h3FF0_0000_0000_0000;
    localparam logic [FLEN-1:0] F2   = 64'h4000_0000_0000_0000;
    localparam logic [FLEN-1:0] F3   = 64'h4008_0000_0000_0000;
    localparam logic [FLEN-1:0] F4   = 64'h4010_0000_0000_0000;
    localparam logic [FLEN-1:0] F5   = 64'h4014_0000_0000_0000;
    localparam logic [FLEN-1:0] F6   = 64'h4018_0000_0000_0000;
    localparam logic [FLEN-1:0] F7   = 64'h401C_0000_0000_0000;
    localparam logic [FLEN-1:0] F8   = 64'h4020_0000_0000_0000;
    localparam logic [FLEN-1:0] F9   = 64'h4022_0000_0000_0000;
    localparam logic [FLEN-1:0] FINF = 64'h7FF0_0000_0000_0000;
    localparam logic [FLEN-1:0] FNZ  = 64'h8000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    float_triplet_collector_if #(.FLEN(FLEN)) bus ();

    float_triplet_collector #(.FLEN(FLEN), .EXP_W(EXP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: words waiting in the collector, the held output triple, and the
    // full accepted-word history used for the ordering scoreboard.
    logic [FLEN-1:0]   pend [$];
    logic [FLEN-1:0]   seq  [$];
    logic [3*FLEN-1:0] out_data;
    bit                out_valid;
    int                n_cmp = 0;
    int                n_bad = 0;

    task automatic chk(input string tag, input logic [3*FLEN-1:0] obs, input logic [3*FLEN-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit word_special(input logic [FLEN-1:0] w);
        return w[FLEN-2 -: EXP_W] == {EXP_W{1'b1}};
    endfunction

    task automatic check_outputs();
        chk("up_ready", bus.up_ready, (rst == 1'b0 && pend.size() != 3) ? 1'b1 : 1'b0);
        chk("down_valid", bus.down_valid, out_valid);
        if (out_valid) begin
            chk("down_data", bus.down_data, out_data);
`ifdef FLOAT_TRIPLET_SPECIAL_EN
            chk("down_special", bus.down_special,
                word_special(out_data[3*FLEN-1 -: FLEN]) || word_special(out_data[2*FLEN-1 -: FLEN])
                || word_special(out_data[FLEN-1:0]));
`endif
        end
    endtask

    task automatic load_from_pend();
        out_data  = {pend[0], pend[1], pend[2]};
        out_valid = 1'b1;
        pend.delete();
    endtask

    task automatic cycle(input bit v, input logic [FLEN-1:0] d, input bit dr);
        bit rdy, acc, free;
        logic [FLEN-1:0] s0, s1, s2;
        bus.up_valid   = v;
        bus.up_data    = d;
        bus.down_ready = dr;
        rdy  = pend.size() != 3;
        acc  = v && rdy;
        free = !out_valid || dr;
        if (out_valid && dr) begin
            if (seq.size() >= 3) begin
                s0 = seq.pop_front();
                s1 = seq.pop_front();
                s2 = seq.pop_front();
                chk("order", bus.down_data, {s0, s1, s2});
            end else begin
                chk("order_underflow", seq.size(), 3);
            end
            out_valid = 1'b0;
        end
        if (pend.size() == 3) begin
            if (free) load_from_pend();
        end else if (acc) begin
            pend.push_back(d);
            seq.push_back(d);
            if (pend.size() == 3 && free) load_from_pend();
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.up_valid   = 1'b0;
        bus.up_data    = '0;
        bus.down_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        pend.delete();
        seq.delete();
        out_valid = 1'b0;
        out_data  = '0;
        chk("rst_up_ready", bus.up_ready, 1'b0);
        chk("rst_down_valid", bus.down_valid, 1'b0);
        chk("rst_down_data", bus.down_data, '0);
`ifdef FLOAT_TRIPLET_SPECIAL_EN
        chk("rst_down_special", bus.down_special, 1'b0);
`endif
        rst = 1'b0;
    endtask

    initial begin
        logic [FLEN-1:0] w;
        do_reset();
        cycle(0, '0, 1);

        // Streaming: two triples back to back, valid one cycle after each 3rd word.
        cycle(1, F1, 1); cycle(1, F2, 1); cycle(1, F3, 1);
        chk("stream_t1", {bus.down_valid, bus.down_data}, {1'b1, F1, F2, F3});
        cycle(1, F4, 1); cycle(1, F5, 1); cycle(1, F6, 1);
        chk("stream_t2", {bus.down_valid, bus.down_data}, {1'b1, F4, F5, F6});
        cycle(0, '0, 1);
        chk("stream_drained", bus.down_valid, 1'b0);

        // Backpressure: fill both buffers, then one drain cycle.
        for (int i = 0; i < 6; i++) cycle(1, F1 + FLEN'(i), 0);
        chk("bp_full_ready", bus.up_ready, 1'b0);
        chk("bp_hold", bus.down_data, {F1, F1 + 64'd1, F1 + 64'd2});
        cycle(1, F9, 0);
        chk("bp_still_held", {bus.up_ready, bus.down_data}, {1'b0, F1, F1 + 64'd1, F1 + 64'd2});
        cycle(0, '0, 1);
        chk("bp_t2", {bus.down_valid, bus.down_data}, {1'b1, F1 + 64'd3, F1 + 64'd4, F1 + 64'd5});
        chk("bp_ready_back", bus.up_ready, 1'b1);
        cycle(0, '0, 1);

        // Simultaneous drain and load.
        cycle(1, F1, 0); cycle(1, F2, 0); cycle(1, F3, 0);
        cycle(1, F4, 0); cycle(1, F5, 0);
        cycle(1, F6, 1);
        chk("drain_load", {bus.down_valid, bus.down_data}, {1'b1, F4, F5, F6});
        cycle(0, '0, 1);

        // Reset after two words.
        cycle(1, F1, 1); cycle(1, F2, 1);
        do_reset();
        cycle(1, F7, 1); cycle(1, F8, 1); cycle(1, F9, 1);
        chk("post_reset", {bus.down_valid, bus.down_data}, {1'b1, F7, F8, F9});
        cycle(0, '0, 1);

        // Gapped input.
        cycle(1, F1, 1); cycle(0, F9, 1); cycle(1, F2, 1); cycle(0, F9, 1);
        chk("gap_no_valid", bus.down_valid, 1'b0);
        cycle(1, F3, 1);
        chk("gap_triple", {bus.down_valid, bus.down_data}, {1'b1, F1, F2, F3});
        cycle(0, '0, 1);

`ifdef FLOAT_TRIPLET_SPECIAL_EN
        cycle(1, F1, 1); cycle(1, FINF, 1); cycle(1, F2, 1);
        chk("special_inf", bus.down_special, 1'b1);
        cycle(1, F1, 1); cycle(1, FNZ, 1); cycle(1, F2, 1);
        chk("special_negzero", bus.down_special, 1'b0);
        cycle(0, '0, 1);
`endif

        // Random traffic with occasional resets and special values.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                w = {$urandom, $urandom};
                if ($urandom_range(0, 7) == 0) w[FLEN-2 -: EXP_W] = '1;
                cycle($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
